// File: rtl/p_hit_pkg.sv
// Shared types for the hit-point stage: Q-format scalars, 3-vectors and
// full-width products.
package p_hit_pkg;
    localparam int Q_BITS_DEFAULT = 16;

    typedef logic signed [31:0] fix_t;
    typedef fix_t [2:0]         vec3_t;
    typedef logic signed [63:0] prod_t;
endpackage

// File: rtl/p_hit_point_if.sv
// Handshake bundle of p_hit_point: upstream t FIFO pop, ray push and
// result FIFO pop.
interface p_hit_point_if;
    import p_hit_pkg::*;

    fix_t  t_in;
    logic  t_empty;
    logic  t_rd_en;
    vec3_t origin;
    vec3_t dir;
    logic  in_wr_en;
    logic  in_full;
    vec3_t out;
    logic  out_hit;
    logic  out_empty;
    logic  out_rd_en;

    modport slave (
        input  t_in, t_empty, origin, dir, in_wr_en, out_rd_en,
        output t_rd_en, in_full, out, out_hit, out_empty
    );

    modport master (
        output t_in, t_empty, origin, dir, in_wr_en, out_rd_en,
        input  t_rd_en, in_full, out, out_hit, out_empty
    );
endinterface

// File: rtl/fifo_array.sv
// First-word fall-through FIFO of ARRAY_SIZE x WIDTH words, array storage
// with a registered head word (write-through bypass when the FIFO drains).
module fifo_array #(
    parameter int WIDTH      = 32,
    parameter int ARRAY_SIZE = 3,
    parameter int DEPTH      = 16
) (
    input  logic                              clk,
    input  logic                              srst,
    input  logic                              wr_en,
    input  logic [ARRAY_SIZE-1:0][WIDTH-1:0]  din,
    input  logic                              rd_en,
    output logic [ARRAY_SIZE-1:0][WIDTH-1:0]  dout,
    output logic                              empty,
    output logic                              full,
    output logic [$clog2(DEPTH):0]            count
);
    localparam int AW = $clog2(DEPTH);

    typedef logic [ARRAY_SIZE-1:0][WIDTH-1:0] word_t;

    word_t         mem [DEPTH];
    word_t         dout_reg;
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW-1:0] rd_ptr_next;
    logic [AW:0]   count_reg;
    logic [AW:0]   count_next;
    logic          wr_ok;
    logic          rd_ok;

    assign empty       = (count_reg == '0);
    assign full        = (count_reg == (AW+1)'(DEPTH));
    assign rd_ok       = rd_en && !empty;
    // A full FIFO still accepts a write when the same cycle frees a slot.
    assign wr_ok       = wr_en && (!full || rd_ok);
    assign rd_ptr_next = rd_ok ? rd_ptr_reg + AW'(1) : rd_ptr_reg;

    always_comb begin
        count_next = count_reg;
        if (wr_ok && !rd_ok) begin
            count_next = count_reg + (AW+1)'(1);
        end else if (rd_ok && !wr_ok) begin
            count_next = count_reg - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            dout_reg   <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            // Head word lands in the slot being written only when the FIFO
            // is (or becomes) otherwise empty; the array read would be stale.
            if (wr_ok && (wr_ptr_reg == rd_ptr_next)) begin
                dout_reg <= din;
            end else if (count_next != '0) begin
                dout_reg <= mem[rd_ptr_next];
            end
        end
    end

    assign dout  = dout_reg;
    assign count = count_reg;
endmodule

// File: rtl/p_hit_point_lane.sv
// One axis of P = origin + t*dir: stage 1 multiplies, stage 2 realigns the
// Q product and adds the origin with plain 32-bit wrap.
module p_hit_point_lane
    import p_hit_pkg::*;
#(
    parameter int Q_BITS = Q_BITS_DEFAULT
) (
    input  logic clk,
    input  logic srst,
    input  fix_t t,
    input  fix_t origin,
    input  fix_t dir,
    output fix_t p
);
    prod_t prod_reg;
    fix_t  origin_reg;
    fix_t  p_reg;
    logic  unused_prod_bits;

    always_ff @(posedge clk) begin
        if (srst) begin
            prod_reg   <= '0;
            origin_reg <= '0;
            p_reg      <= '0;
        end else begin
            prod_reg   <= prod_t'(t) * prod_t'(dir);
            origin_reg <= origin;
            p_reg      <= origin_reg + fix_t'(prod_reg[Q_BITS+31:Q_BITS]);
        end
    end

    assign unused_prod_bits = ^{prod_reg[63:Q_BITS+32], prod_reg[Q_BITS-1:0]};
    assign p = p_reg;
endmodule

// File: rtl/p_hit_point.sv
// Pairs each t popped from the upstream FIFO with its buffered ray, computes
// the hit point and queues it with a front-of-ray flag on a FWFT output FIFO.
module p_hit_point
    import p_hit_pkg::*;
#(
    parameter int Q_BITS    = Q_BITS_DEFAULT,
    parameter int RAY_DEPTH = 1024,
    parameter int OUT_DEPTH = 16
) (
    input logic          clock,
    input logic          reset,
    p_hit_point_if.slave bus
);
    localparam int RAW = $clog2(RAY_DEPTH);
    localparam int OAW = $clog2(OUT_DEPTH);

    logic           push;
    logic           issue;
    logic           ray_empty;
    logic           origin_empty;
    logic           dir_empty;
    logic           origin_full;
    logic           dir_full;
    vec3_t          origin_head;
    vec3_t          dir_head;
    vec3_t          p_word;
    logic [RAW:0]   origin_count;
    logic [RAW:0]   dir_count;
    logic [OAW:0]   out_count;
    logic [OAW:0]   hit_count;
    logic           out_data_empty;
    logic           out_data_full;
    logic           hit_empty;
    logic           hit_full;
    logic           hit_word;
    logic [1:0]     inflight_reg;
    logic [1:0]     inflight_next;
    logic           valid_s1_reg;
    logic           valid_s2_reg;
    logic           hit_s1_reg;
    logic           hit_s2_reg;
    logic [OAW+1:0] credits_used;
    logic           unused_status;

    // Pushes while full are dropped, even if the same cycle pops a ray.
    assign push = bus.in_wr_en && !bus.in_full;

    fifo_array #(.WIDTH(32), .ARRAY_SIZE(3), .DEPTH(RAY_DEPTH)) u_origin_fifo (
        .clk(clock), .srst(reset), .wr_en(push), .din(bus.origin), .rd_en(issue),
        .dout(origin_head), .empty(origin_empty), .full(origin_full), .count(origin_count)
    );

    fifo_array #(.WIDTH(32), .ARRAY_SIZE(3), .DEPTH(RAY_DEPTH)) u_dir_fifo (
        .clk(clock), .srst(reset), .wr_en(push), .din(bus.dir), .rd_en(issue),
        .dout(dir_head), .empty(dir_empty), .full(dir_full), .count(dir_count)
    );

    assign ray_empty   = origin_empty || dir_empty;
    assign bus.in_full = origin_full || dir_full;

    // Queued plus in-flight results may never exceed the output FIFO depth.
    assign credits_used = (OAW+2)'(out_count) + (OAW+2)'(inflight_reg);
    assign issue        = !reset && !bus.t_empty && !ray_empty
                          && (credits_used < (OAW+2)'(OUT_DEPTH));
    assign bus.t_rd_en  = issue;

    for (genvar gi = 0; gi < 3; gi++) begin : g_lane
        p_hit_point_lane #(.Q_BITS(Q_BITS)) u_lane (
            .clk(clock), .srst(reset), .t(bus.t_in),
            .origin(origin_head[gi]), .dir(dir_head[gi]), .p(p_word[gi])
        );
    end

    always_comb begin
        inflight_next = inflight_reg;
        case ({issue, valid_s2_reg})
            2'b10:   inflight_next = inflight_reg + 2'd1;
            2'b01:   inflight_next = inflight_reg - 2'd1;
            default: inflight_next = inflight_reg;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_s1_reg <= 1'b0;
            valid_s2_reg <= 1'b0;
            hit_s1_reg   <= 1'b0;
            hit_s2_reg   <= 1'b0;
            inflight_reg <= 2'd0;
        end else begin
            valid_s1_reg <= issue;
            valid_s2_reg <= valid_s1_reg;
            hit_s1_reg   <= ($signed(bus.t_in) > 32'sd0);
            hit_s2_reg   <= hit_s1_reg;
            inflight_reg <= inflight_next;
        end
    end

    fifo_array #(.WIDTH(32), .ARRAY_SIZE(3), .DEPTH(OUT_DEPTH)) u_out_fifo (
        .clk(clock), .srst(reset), .wr_en(valid_s2_reg), .din(p_word), .rd_en(bus.out_rd_en),
        .dout(bus.out), .empty(out_data_empty), .full(out_data_full), .count(out_count)
    );

    fifo_array #(.WIDTH(1), .ARRAY_SIZE(1), .DEPTH(OUT_DEPTH)) u_hit_fifo (
        .clk(clock), .srst(reset), .wr_en(valid_s2_reg), .din(hit_s2_reg), .rd_en(bus.out_rd_en),
        .dout(hit_word), .empty(hit_empty), .full(hit_full), .count(hit_count)
    );

    assign bus.out_empty = out_data_empty;
    assign bus.out_hit   = hit_word;

    assign unused_status = ^{origin_count, dir_count, hit_count, hit_empty, out_data_full, hit_full};
endmodule

// File: tb/tb_p_hit_point.sv
// Directed bench for p_hit_point: upstream t FIFO model, scoreboard of
// expected hit points, directed values for the documented corner cases.
module tb_p_hit_point;
    import p_hit_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    p_hit_point_if bus ();

    p_hit_point #(.Q_BITS(16), .RAY_DEPTH(1024), .OUT_DEPTH(16)) dut (
        .clock(clk),
        .reset(reset),
        .bus(bus)
    );

    typedef struct packed { vec3_t p; logic hit; } result_t;
    typedef struct packed { vec3_t o; vec3_t d; } ray_t;

    result_t exp_q[$];
    ray_t    mray_q[$];
    fix_t    mt_q[$];
    fix_t    t_q[$];

    int    checks    = 0;
    int    failures  = 0;
    int    cyc       = 0;
    int    issues    = 0;
    int    pops      = 0;
    int    first_ne  = -1;
    int    issue_cyc = -1;
    logic  drain     = 1'b0;
    vec3_t last_out  = '0;
    logic  last_hit  = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, want);
        end
    endtask

    function automatic result_t model(input fix_t t, input ray_t r);
        result_t e;
        longint  prod;
        for (int i = 0; i < 3; i++) begin
            prod     = longint'($signed(t)) * longint'($signed(r.d[i]));
            e.p[i]   = r.o[i] + fix_t'(prod >>> 16);
        end
        e.hit = (t > 0);
        return e;
    endfunction

    task automatic pair_model();
        while (mray_q.size() != 0 && mt_q.size() != 0) begin
            exp_q.push_back(model(mt_q.pop_front(), mray_q.pop_front()));
        end
    endtask

    task automatic push_ray(input vec3_t o, input vec3_t d);
        ray_t r;
        r.o = o;
        r.d = d;
        bus.origin   = o;
        bus.dir      = d;
        bus.in_wr_en = 1'b1;
        mray_q.push_back(r);
        pair_model();
    endtask

    task automatic push_t(input fix_t t);
        t_q.push_back(t);
        mt_q.push_back(t);
        pair_model();
    endtask

    // One clock: present upstream head, sample/score away from the edge,
    // then retire the upstream pop on the edge.
    task automatic tick();
        logic    issued;
        result_t want;
        bus.t_empty   = (t_q.size() == 0);
        bus.t_in      = (t_q.size() != 0) ? t_q[0] : '0;
        bus.out_rd_en = drain;
        #1;
        issued = bus.t_rd_en;
        if (bus.t_empty) check("rd_en_when_t_empty", 32'(bus.t_rd_en), 32'd0);
        if (!bus.out_empty && first_ne < 0) first_ne = cyc;
        if (drain && !bus.out_empty) begin
            pops++;
            last_out = bus.out;
            last_hit = bus.out_hit;
            check("output_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                want = exp_q.pop_front();
                for (int i = 0; i < 3; i++) check($sformatf("sb_out%0d", i), bus.out[i], want.p[i]);
                check("sb_hit", 32'(bus.out_hit), 32'(want.hit));
            end
        end
        if (issued) issue_cyc = cyc;
        @(posedge clk);
        cyc++;
        if (issued) begin
            issues++;
            if (t_q.size() != 0) void'(t_q.pop_front());
        end
        @(negedge clk);
        bus.in_wr_en = 1'b0;
    endtask

    task automatic reset_cycle(input int n);
        reset = 1'b1;
        drain = 1'b0;
        t_q.delete();
        exp_q.delete();
        mray_q.delete();
        mt_q.delete();
        repeat (n) tick();
        reset = 1'b0;
    endtask

    task automatic drain_all(input string tag, input int bound);
        int n;
        n     = 0;
        drain = 1'b1;
        while (exp_q.size() != 0 && n < bound) begin
            tick();
            n++;
        end
        drain = 1'b0;
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        vec3_t o;
        vec3_t d;
        int    base;
        int    pbase;

        bus.t_in      = '0;
        bus.t_empty   = 1'b1;
        bus.origin    = '0;
        bus.dir       = '0;
        bus.in_wr_en  = 1'b0;
        bus.out_rd_en = 1'b0;
        @(negedge clk);
        reset_cycle(3);

        check("rst_t_rd_en", 32'(bus.t_rd_en), 32'd0);
        check("rst_in_full", 32'(bus.in_full), 32'd0);
        check("rst_out_empty", 32'(bus.out_empty), 32'd1);
        check("rst_out0", bus.out[0], 32'd0);
        check("rst_out1", bus.out[1], 32'd0);
        check("rst_out2", bus.out[2], 32'd0);
        check("rst_out_hit", 32'(bus.out_hit), 32'd0);
        check("rst_inflight", 32'(dut.inflight_reg), 32'd0);

        // Basic hit with latency measurement
        o[0] = 32'h00010000; o[1] = 32'h00020000; o[2] = 32'h00030000;
        d[0] = 32'h00008000; d[1] = 32'hFFFF0000; d[2] = 32'h00000000;
        first_ne  = -1;
        issue_cyc = -1;
        push_ray(o, d);
        push_t(32'h00020000);
        repeat (6) tick();
        check("basic_issue_to_ready", 32'(first_ne - issue_cyc), 32'd3);
        drain_all("basic_drain", 10);
        check("basic_x", last_out[0], 32'h00020000);
        check("basic_y", last_out[1], 32'h00000000);
        check("basic_z", last_out[2], 32'h00030000);
        check("basic_hit", 32'(last_hit), 32'd1);

        // Point behind the origin
        o = '0;
        d = '0;
        d[0] = 32'h00010000;
        push_ray(o, d);
        push_t(32'hFFFF0000);
        drain_all("behind_drain", 20);
        check("behind_x", last_out[0], 32'hFFFF0000);
        check("behind_hit", 32'(last_hit), 32'd0);

        // Two's-complement wrap, no saturation
        d[0] = 32'h00020000;
        push_ray(o, d);
        push_t(32'h7FFF0000);
        drain_all("wrap_drain", 20);
        check("wrap_x", last_out[0], 32'hFFFE0000);
        check("wrap_hit", 32'(last_hit), 32'd1);

        // Backpressure: credits stop issue at the output depth
        base  = issues;
        pbase = pops;
        for (int k = 0; k < 20; k++) begin
            for (int i = 0; i < 3; i++) begin
                o[i] = fix_t'($urandom);
                d[i] = fix_t'($urandom);
            end
            push_ray(o, d);
            push_t(fix_t'($urandom));
            tick();
        end
        repeat (30) tick();
        check("bp_issues_held", 32'(issues - base), 32'd16);
        check("bp_out_empty", 32'(bus.out_empty), 32'd0);
        check("bp_rd_en_low", 32'(bus.t_rd_en), 32'd0);
        drain_all("bp_drain", 200);
        check("bp_issues_total", 32'(issues - base), 32'd20);
        check("bp_pops_total", 32'(pops - pbase), 32'd20);
        check("bp_empty_after", 32'(bus.out_empty), 32'd1);

        // Starvation: t waiting, no ray
        base = issues;
        push_t(32'h00010000);
        repeat (3) tick();
        check("starve_no_issue", 32'(issues - base), 32'd0);
        check("starve_rd_en", 32'(bus.t_rd_en), 32'd0);
        o = '0; o[1] = 32'h00050000;
        d = '0; d[1] = 32'h00010000;
        push_ray(o, d);
        tick();
        check("starve_issue_next", 32'(bus.t_rd_en), 32'd1);
        tick();
        check("starve_one_issue", 32'(issues - base), 32'd1);
        drain_all("starve_drain", 20);
        check("starve_y", last_out[1], 32'h00060000);

        // Reset one cycle after an issue discards everything
        base = issues;
        push_ray(o, d);
        push_ray(o, d);
        push_t(32'h00030000);
        tick();
        tick();
        check("rst_mid_issued", 32'(issues - base), 32'd1);
        reset_cycle(1);
        check("rst_mid_out_empty", 32'(bus.out_empty), 32'd1);
        check("rst_mid_inflight", 32'(dut.inflight_reg), 32'd0);
        first_ne = -1;
        repeat (5) tick();
        check("rst_mid_no_stray", 32'(first_ne), 32'hFFFFFFFF);
        push_t(32'h00010000);
        tick();
        check("rst_mid_ray_fifo_empty", 32'(bus.t_rd_en), 32'd0);
        check("rst_mid_issue_count", 32'(issues - base), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
